game_tick_gen: RTL and testbench

GAME_TICK_GEN -- requirements
Module: game_tick_gen

---
 rtl/game_tick_gen.sv | 157 +++++++++++++++
 tb/tb_game_tick_gen.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/game_tick_gen.sv
// Multi-channel programmable tick generator for game timing: periodic or one-shot
// down-counters with global pause, per-channel speedup and period readback.
module game_tick_gen #(
  parameter int unsigned CHANNELS       = 2,
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned DEFAULT_PERIOD = 25_000_000,
  parameter int unsigned MIN_PERIOD     = 2,
  parameter int unsigned STEP           = 1_000_000,
  localparam int unsigned CH_W          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [WIDTH-1:0]    cfg_period,
  input  logic                cfg_oneshot,
  input  logic [CHANNELS-1:0] ch_en,
  input  logic                pause,
  input  logic [CHANNELS-1:0] speedup,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] done,
  input  logic [CH_W-1:0]     rd_ch,
  output logic [WIDTH-1:0]    rd_period
);

  localparam logic [WIDTH-1:0] MIN_P = WIDTH'(MIN_PERIOD);
  localparam logic [WIDTH-1:0] RST_P = (DEFAULT_PERIOD > MIN_PERIOD) ? WIDTH'(DEFAULT_PERIOD) : MIN_P;
  localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1'b1);

  // Requested period clamped to the floor.
  function automatic logic [WIDTH-1:0] clamp_period(input logic [WIDTH-1:0] p);
    logic [WIDTH-1:0] r;
    if (p < MIN_P) begin
      r = MIN_P;
    end else begin
      r = p;
    end
    return r;
  endfunction

  // Period after one speedup step; 64-bit math keeps STEP+MIN from wrapping.
  function automatic logic [WIDTH-1:0] shorten_period(input logic [WIDTH-1:0] p);
    logic [63:0]      p_wide;
    logic [WIDTH-1:0] r;
    p_wide = 64'(p);
    if (p_wide > (64'(STEP) + 64'(MIN_PERIOD))) begin
      r = WIDTH'(p_wide - 64'(STEP));
    end else begin
      r = MIN_P;
    end
    return r;
  endfunction

  logic [WIDTH-1:0]    period_r [CHANNELS];
  logic [WIDTH-1:0]    count_r  [CHANNELS];
  logic [CHANNELS-1:0] mode_r;
  logic [CHANNELS-1:0] done_r;
  logic [CHANNELS-1:0] tick_r;

  logic [WIDTH-1:0]    period_s [CHANNELS];
  logic [WIDTH-1:0]    count_s  [CHANNELS];
  logic [CHANNELS-1:0] mode_s;
  logic [CHANNELS-1:0] done_s;
  logic [CHANNELS-1:0] tick_s;
  logic [CHANNELS-1:0] cfg_hit_s;
  logic [CHANNELS-1:0] active_s;
  logic [WIDTH-1:0]    cfg_pc_s;
  logic [WIDTH-1:0]    rd_period_s;

  // Per-channel write decode and run qualification.
  always_comb begin
    cfg_hit_s = '0;
    active_s  = '0;
    cfg_pc_s  = clamp_period(cfg_period);
    for (int i = 0; i < CHANNELS; i++) begin
      cfg_hit_s[i] = cfg_we && (cfg_ch == CH_W'(i));
      active_s[i]  = ch_en[i] && !pause && !(mode_r[i] && done_r[i]);
    end
  end

  // Next-state for every channel; a config write overrides counting and speedup.
  always_comb begin
    mode_s = mode_r;
    done_s = done_r;
    tick_s = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      period_s[i] = period_r[i];
      count_s[i]  = count_r[i];
      if (cfg_hit_s[i]) begin
        period_s[i] = cfg_pc_s;
        count_s[i]  = cfg_pc_s - ONE_W;
        mode_s[i]   = cfg_oneshot;
        done_s[i]   = 1'b0;
      end else begin
        if (active_s[i]) begin
          if (count_r[i] == '0) begin
            // Reload sees the pre-speedup period; a new one applies next reload.
            count_s[i] = period_r[i] - ONE_W;
            tick_s[i]  = 1'b1;
            if (mode_r[i]) begin
              done_s[i] = 1'b1;
            end else begin
              done_s[i] = done_r[i];
            end
          end else begin
            count_s[i] = count_r[i] - ONE_W;
          end
        end else begin
          count_s[i] = count_r[i];
        end
        if (speedup[i]) begin
          period_s[i] = shorten_period(period_r[i]);
        end else begin
          period_s[i] = period_r[i];
        end
      end
    end
  end

  // Channel state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        period_r[i] <= RST_P;
        count_r[i]  <= RST_P - ONE_W;
      end
      mode_r <= '0;
      done_r <= '0;
      tick_r <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        period_r[i] <= period_s[i];
        count_r[i]  <= count_s[i];
      end
      mode_r <= mode_s;
      done_r <= done_s;
      tick_r <= tick_s;
    end
  end

  // Period readback mux; unmatched channel numbers read as zero.
  always_comb begin
    rd_period_s = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (rd_ch == CH_W'(i)) begin
        rd_period_s = period_r[i];
      end else begin
        rd_period_s = rd_period_s;
      end
    end
  end

  assign tick      = tick_r;
  assign done      = done_r;
  assign rd_period = rd_period_s;

endmodule

// File: tb/tb_game_tick_gen.sv
// Directed table-driven bench for game_tick_gen (CHANNELS=2, DEFAULT_PERIOD=5, MIN_PERIOD=2, STEP=2).
module tb_game_tick_gen;

  localparam int NV = 54;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       cfg_we;
  logic [0:0] cfg_ch;
  logic [7:0] cfg_period;
  logic       cfg_oneshot;
  logic [1:0] ch_en;
  logic       pause;
  logic [1:0] speedup;
  logic [1:0] tick;
  logic [1:0] done;
  logic [0:0] rd_ch;
  logic [7:0] rd_period;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       we;
    logic       ch;
    logic [7:0] per;
    logic       os;
    logic [1:0] en;
    logic       pa;
    logic [1:0] sp;
    logic       rc;
    logic [1:0] etick;
    logic [1:0] edone;
    logic [7:0] erd;
  } vec_t;

  vec_t vec [1:NV];

  always #5 clk = ~clk;

  game_tick_gen #(
    .CHANNELS(2), .WIDTH(8), .DEFAULT_PERIOD(5), .MIN_PERIOD(2), .STEP(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_period(cfg_period), .cfg_oneshot(cfg_oneshot), .ch_en(ch_en),
    .pause(pause), .speedup(speedup), .tick(tick), .done(done),
    .rd_ch(rd_ch), .rd_period(rd_period)
  );

  task automatic check(input string name, input int step, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got=%0h expected=%0h", name, step, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0; cfg_we = 1'b0; cfg_ch = 1'b0; cfg_period = 8'd0; cfg_oneshot = 1'b0;
    ch_en = 2'b11; pause = 1'b0; speedup = 2'b00; rd_ch = 1'b0;

    // Background values; step k is the k-th edge after reset release.
    for (int k = 1; k <= NV; k++) begin
      vec[k].we = 1'b0; vec[k].ch = 1'b0; vec[k].per = 8'd0; vec[k].os = 1'b0;
      vec[k].sp = 2'b00; vec[k].etick = 2'b00;
      vec[k].en = (k <= 32) ? 2'b11 : ((k <= 50) ? 2'b01 : 2'b11);
      vec[k].pa = (k >= 34 && k <= 40) ? 1'b1 : 1'b0;
      vec[k].rc = (k >= 16 && k <= 32) ? 1'b1 : 1'b0;
      if (k <= 15)      vec[k].erd = 8'd5;
      else if (k <= 23) vec[k].erd = 8'd5;
      else if (k == 24) vec[k].erd = 8'd3;
      else if (k <= 32) vec[k].erd = 8'd2;
      else if (k <= 45) vec[k].erd = 8'd3;
      else              vec[k].erd = 8'd2;
      if (k <= 18)      vec[k].edone = 2'b00;
      else if (k <= 32) vec[k].edone = 2'b01;
      else if (k <= 52) vec[k].edone = 2'b00;
      else              vec[k].edone = 2'b10;
    end
    // Both channels tick every 5 after release.
    vec[5].etick = 2'b11; vec[10].etick = 2'b11; vec[15].etick = 2'b11;
    // One-shot on ch0, period 3.
    vec[16].we = 1'b1; vec[16].ch = 1'b0; vec[16].per = 8'd3; vec[16].os = 1'b1;
    vec[19].etick = 2'b01; vec[20].etick = 2'b10;
    // Four speedups on ch1: 5 -> 3 -> 2 -> 2 -> 2; reload at 25 still uses 3.
    for (int k = 24; k <= 27; k++) vec[k].sp = 2'b10;
    vec[25].etick = 2'b10; vec[28].etick = 2'b10; vec[30].etick = 2'b10; vec[32].etick = 2'b10;
    // Periodic ch0 period 3, then pause for 7 cycles holding C=2.
    vec[33].we = 1'b1; vec[33].ch = 1'b0; vec[33].per = 8'd3; vec[33].os = 1'b0;
    vec[43].etick = 2'b01;
    // Period 0 write with speedup while C==0: clamps to 2, no tick that cycle.
    vec[46].we = 1'b1; vec[46].ch = 1'b0; vec[46].per = 8'd0; vec[46].sp = 2'b01;
    vec[48].etick = 2'b01; vec[50].etick = 2'b01;
    // One-shot ch1 period 2 alongside periodic ch0.
    vec[51].we = 1'b1; vec[51].ch = 1'b1; vec[51].per = 8'd2; vec[51].os = 1'b1;
    vec[52].etick = 2'b01; vec[53].etick = 2'b10; vec[54].etick = 2'b01;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_tick", 0, 32'(tick), 32'h0);
    check("reset_done", 0, 32'(done), 32'h0);
    check("reset_rd", 0, 32'(rd_period), 32'd5);

    reset_n = 1'b1;
    for (int k = 1; k <= NV; k++) begin
      cfg_we = vec[k].we; cfg_ch = vec[k].ch; cfg_period = vec[k].per; cfg_oneshot = vec[k].os;
      ch_en = vec[k].en; pause = vec[k].pa; speedup = vec[k].sp; rd_ch = vec[k].rc;
      cycle();
      check("tick", k, 32'(tick), 32'(vec[k].etick));
      check("done", k, 32'(done), 32'(vec[k].edone));
      check("rd_period", k, 32'(rd_period), 32'(vec[k].erd));
    end

    // Reset mid-count together with a config write and speedups.
    reset_n = 1'b0; cfg_we = 1'b1; cfg_ch = 1'b1; cfg_period = 8'd9; cfg_oneshot = 1'b1;
    speedup = 2'b11; ch_en = 2'b11; pause = 1'b0; rd_ch = 1'b0;
    cycle();
    check("rst_cfg_tick", 100, 32'(tick), 32'h0);
    check("rst_cfg_done", 100, 32'(done), 32'h0);
    check("rst_cfg_rd0", 100, 32'(rd_period), 32'd5);
    rd_ch = 1'b1;
    #1;
    check("rst_cfg_rd1", 100, 32'(rd_period), 32'd5);

    reset_n = 1'b1; cfg_we = 1'b0; speedup = 2'b00;
    for (int c = 1; c <= 5; c++) begin
      cycle();
      check("post_rst_tick", 100 + c, 32'(tick), (c == 5) ? 32'h3 : 32'h0);
      check("post_rst_done", 100 + c, 32'(done), 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
